// File: rtl/add2_bist_pkg.sv
// Shared definitions for the 2-bit adder built-in self-test: FSM encodings,
// default operand width and vector-count helper.
package add2_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_OP_W = 2;

  // Number of operand combinations on a 2*op_w-bit operand bus.
  function automatic int num_vec(input int op_w);
    return 1 << (2 * op_w);
  endfunction

endpackage

// File: rtl/add2_golden.sv
// Combinational reference sum for a packed {A, B} operand bus; reusable by
// any checker that needs the expected adder result.
module add2_golden #(
  parameter int OP_W = 2
) (
  input  logic [2*OP_W-1:0] i_ops,
  output logic [OP_W:0]     o_sum
);

  assign o_sum = {1'b0, i_ops[2*OP_W-1:OP_W]} + {1'b0, i_ops[OP_W-1:0]};

endmodule

// File: rtl/add2_bist.sv
// Self-test initiator/checker: sweeps every operand pair into the adder,
// samples its sum after a settle window and records errors.
module add2_bist
  import add2_bist_pkg::*;
#(
  parameter int OP_W          = DEF_OP_W,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [2*OP_W-1:0]   a_out,
  input  logic [OP_W:0]       s_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2*OP_W:0]     err_count,
  output logic                first_fail_valid,
  output logic [2*OP_W-1:0]   first_fail_vec
);

  localparam int VEC_W = 2 * OP_W;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(num_vec(OP_W) - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [VEC_W-1:0]   r_vec;
  logic [CNT_W-1:0]   r_settle;
  logic [VEC_W:0]     r_err;
  logic               r_ff_valid;
  logic [VEC_W-1:0]   r_ff_vec;
  logic [OP_W:0]      w_gold;
  logic               w_mismatch;

  add2_golden #(.OP_W(OP_W)) u_golden (
    .i_ops (r_vec),
    .o_sum (w_gold)
  );

  assign w_mismatch = (s_in != w_gold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (start) w_next = ST_SETTLE;
      ST_SETTLE:        if (r_settle == '0) w_next = ST_CHECK;
      ST_CHECK:         w_next = (r_vec == LAST_VEC) ? ST_DONE : ST_SETTLE;
      default:          w_next = ST_IDLE;
    endcase
  end

  // The vector register doubles as the operand bus, so a new vector appears
  // on a_out on the same edge that leaves CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec      <= '0;
      r_settle   <= '0;
      r_err      <= '0;
      r_ff_valid <= 1'b0;
      r_ff_vec   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_vec      <= '0;
            r_settle   <= SETTLE_LOAD;
            r_err      <= '0;
            r_ff_valid <= 1'b0;
            r_ff_vec   <= '0;
          end
        end
        ST_SETTLE: begin
          if (r_settle != '0) r_settle <= r_settle - CNT_W'(1);
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            r_err <= r_err + (VEC_W+1)'(1);
            if (!r_ff_valid) begin
              r_ff_valid <= 1'b1;
              r_ff_vec   <= r_vec;
            end
          end
          if (r_vec == LAST_VEC) begin
            r_vec <= '0;
          end else begin
            r_vec    <= r_vec + VEC_W'(1);
            r_settle <= SETTLE_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign a_out            = r_vec;
  assign busy             = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
  assign done             = (r_state == ST_DONE);
  assign pass             = done && (r_err == '0);
  assign err_count        = r_err;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_vec   = r_ff_vec;

endmodule

// File: tb/tb_add2_bist.sv
// Directed bench for add2_bist: correct, stuck-at and all-zero adder models,
// longer settle window, restart/ignored start and mid-sweep reset.
module tb_add2_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start3;
  logic [3:0] a_out, a_out3, ffvec, ffvec3;
  logic [2:0] s_in, s_in3, sum0, sum3;
  logic       busy, done, pass, ffv;
  logic       busy3, done3, pass3, ffv3;
  logic [4:0] err, err3;
  int         mode;
  int         n_chk = 0;
  int         n_pass = 0;
  int         n_fail = 0;
  int         cyc;

  always #5 clk = ~clk;

  // Adder models: 0 = correct, 1 = s[0] stuck-at-0, 2 = output stuck at 000
  always_comb begin
    sum0 = {1'b0, a_out[3:2]} + {1'b0, a_out[1:0]};
    case (mode)
      1:       s_in = sum0 & 3'b110;
      2:       s_in = 3'b000;
      default: s_in = sum0;
    endcase
    sum3  = {1'b0, a_out3[3:2]} + {1'b0, a_out3[1:0]};
    s_in3 = sum3;
  end

  add2_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_out(a_out), .s_in(s_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_fail_valid(ffv), .first_fail_vec(ffvec)
  );

  add2_bist #(.OP_W(2), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a_out(a_out3), .s_in(s_in3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail_valid(ffv3), .first_fail_vec(ffvec3)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_out"}, 32'(a_out), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_pass"},  32'(pass), 0);
    chk({tag, "_err"},   32'(err), 0);
    chk({tag, "_ffv"},   32'(ffv), 0);
    chk({tag, "_ffvec"}, 32'(ffvec), 0);
  endtask

  // Pulse start on dut (called #1 after an edge); returns edges from the
  // accepting edge until done is seen, 0 if the budget expires.
  task automatic run_sweep(input int poke, output int cycles);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_done_low", 32'(done), 0);
    chk("accept_busy", 32'(busy), 1);
    chk("accept_ffv_clear", 32'(ffv), 0);
    chk("accept_err_clear", 32'(err), 0);
    cycles = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      start = (n == poke);
      if (done) begin
        cycles = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    mode   = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // correct adder
    run_sweep(0, cyc);
    chk("good_latency", cyc, 32);
    chk("good_pass", 32'(pass), 1);
    chk("good_err", 32'(err), 0);
    chk("good_ffv", 32'(ffv), 0);
    chk("good_a_out", 32'(a_out), 0);
    chk("good_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("good_done_hold", 32'(done), 1);

    // s[0] stuck-at-0: the 8 odd sums fail, first is 0+1
    mode = 1;
    run_sweep(0, cyc);
    chk("sa0_latency", cyc, 32);
    chk("sa0_err", 32'(err), 8);
    chk("sa0_ffv", 32'(ffv), 1);
    chk("sa0_ffvec", 32'(ffvec), 1);
    chk("sa0_pass", 32'(pass), 0);

    // sum forced to 000: every vector except 0000 fails
    mode = 2;
    run_sweep(0, cyc);
    chk("zero_err", 32'(err), 15);
    chk("zero_ffvec", 32'(ffvec), 1);
    chk("zero_pass", 32'(pass), 0);

    // restart from DONE with a stray start at cycle 10 that must be ignored
    mode = 0;
    run_sweep(10, cyc);
    chk("poke_latency", cyc, 32);
    chk("poke_pass", 32'(pass), 1);
    chk("poke_err", 32'(err), 0);

    // SETTLE_CYCLES = 3: each vector holds 4 cycles, 64 cycles total
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    chk("s3_vec_0", 32'(a_out3), 0);
    chk("s3_busy", 32'(busy3), 1);
    for (int k = 1; k < 64; k++) begin
      @(posedge clk); #1;
      chk($sformatf("s3_vec_%0d", k), 32'(a_out3), k / 4);
    end
    chk("s3_not_done_63", 32'(done3), 0);
    @(posedge clk); #1;
    chk("s3_done_64", 32'(done3), 1);
    chk("s3_pass", 32'(pass3), 1);
    chk("s3_a_out", 32'(a_out3), 0);

    // reset mid-sweep with a faulty adder
    mode  = 2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    chk("mid_err_nonzero", 32'(err != 0), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    chk("midrst_s3_done", 32'(done3), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mode  = 1;
    @(posedge clk); #1;
    run_sweep(0, cyc);
    chk("after_rst_latency", cyc, 32);
    chk("after_rst_err", 32'(err), 8);
    chk("after_rst_ffvec", 32'(ffvec), 1);
    chk("after_rst_pass", 32'(pass), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/add2_bist.md
Name: add2_bist

Overview:
- Hardware initiator/checker for the 2-bit adder (`add2_bits`) interface. The adder takes a packed 4-bit operand bus `{A[3:2], B[1:0]}` and returns a 3-bit sum.
- On `start`, the block drives all 16 operand combinations onto the adder input, waits a settle window, and samples the sum. It checks each sample against an internal golden sum.
- Reports pass/fail, the error count and the first failing vector.
- Sits beside the adder as a built-in self-test. It replaces the manual stimulus sweep with a synthesizable one.

Parameters:
- `OP_W`, 2, width of each operand; operand bus is `2*OP_W` bits, sum bus is `OP_W+1` bits.
- `SETTLE_CYCLES`, 1, cycles operands are held before the sum is sampled; legal range ≥ 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- `a_out`  out  `2*OP_W`  operand bus to the adder; `a_out[2*OP_W-1:OP_W]` = A, `a_out[OP_W-1:0]` = B.
- `s_in`  in  `OP_W+1`  sum returned by the adder under test.
- `busy`  out  1  high while a sweep is in progress (SETTLE or CHECK).
- `done`  out  1  high from sweep completion until the next accepted `start` or reset.
- `pass`  out  1  `done && (err_count == 0)`.
- `err_count`  out  `2*OP_W+1`  number of mismatching vectors in the current/last sweep.
- `first_fail_valid`  out  1  at least one mismatch recorded.
- `first_fail_vec`  out  `2*OP_W`  operand vector of the first mismatch.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - `a_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0.
  - `first_fail_valid`=0, `first_fail_vec`=0.
  - Vector counter and settle counter are 0.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE → SETTLE on `start`:
  - vector counter and `a_out` are set to 0.
  - `err_count`, `first_fail_*` and `done` are cleared.
  - settle counter is loaded with `SETTLE_CYCLES-1`.
- SETTLE:
  - `a_out` is held stable.
  - The counter decrements each cycle; on reaching 0, go to CHECK.
  - Dwell is exactly `SETTLE_CYCLES` cycles.
- CHECK (exactly 1 cycle):
  - Compare `s_in` against golden = zero-extended A + zero-extended B, `OP_W+1` bits, no overflow possible.
  - On mismatch, `err_count` increments. If `first_fail_valid`=0, capture `first_fail_vec`=`a_out` and set `first_fail_valid`.
  - If the vector counter equals `2**(2*OP_W)-1`: go to DONE and set `a_out`=0.
  - Otherwise: increment the vector counter, drive the new value on `a_out` on the same edge, reload the settle counter, and return to SETTLE.
- DONE:
  - `done`=1 and `busy`=0; results hold.
  - `start` restarts the sweep exactly as from IDLE.
- Timing:
  - Each vector occupies `SETTLE_CYCLES+1` cycles.
  - The full sweep takes `2**(2*OP_W) * (SETTLE_CYCLES+1)` cycles from the `start` edge to `done` rising; 32 cycles at defaults.
  - Vectors are applied in ascending order: 0000, 0001, …, 1111.
- `start` while `busy` is ignored with no side effects.
- `err_count` width holds the maximum of 16 errors; no saturation is needed.
- Reset mid-sweep returns immediately to reset values; the partial results are discarded.
- `s_in` is sampled only in CHECK; glitches during SETTLE are irrelevant.

Decomposition:
- Shared header `add2_defs.vh`:
  - state encodings `ST_IDLE`/`ST_SETTLE`/`ST_CHECK`/`ST_DONE`;
  - default `OP_W`;
  - `NUM_VEC` = `2**(2*OP_W)`.
- One natural sub-module, `add2_golden`: a combinational reference sum (operand bus in, `OP_W+1` sum out), reusable by other checkers.
- The FSM, counters and result registers stay in `add2_bist`.

Test Plan:
- Correct `add2_bits` connected, default params, pulse `start` → `done` rises exactly 32 cycles later; `pass`=1, `err_count`=0, `first_fail_valid`=0, `a_out`=0.
- Adder replaced by model with `s[0]` stuck-at-0 → `err_count`=8 (odd sums), `first_fail_vec`=4'b0001, `pass`=0.
- `s_in` forced to 3'b000 → `err_count`=15, `first_fail_vec`=4'b0001; only vector 0000 passes.
- `SETTLE_CYCLES`=3 with correct adder → `done` after 64 cycles; `a_out` stable for 4 cycles per vector, sequence 0..15.
- `start` pulsed again at cycle 10 of a sweep → ignored, `done` still at cycle 32. Then `start` in DONE → `done` drops next cycle, counts cleared, and the new sweep completes 32 cycles later.
- `rst_n` asserted at cycle 17 with a faulty adder → all outputs 0 immediately; a fresh `start` after release yields a full-sweep result independent of the aborted run.
